// File: rtl/pic_bus_pkg.sv
// Shared types and command-word bit positions for the 8259A-style PIC bus interface.
package pic_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } pic_state_t;

   localparam int ICW1_SEL = 4;
   localparam int OCW3_SEL = 3;
   localparam int SNGL     = 1;
   localparam int IC4      = 0;
   localparam int OCW3_RR  = 1;
   localparam int OCW3_RIS = 0;
   localparam int OCW3_P   = 2;

endpackage

// File: rtl/pic_strobe_sync.sv
// Multi-stage synchroniser for an active-low host strobe, with a rising-edge (release) detector.
module pic_strobe_sync
   import pic_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // The chain idles at the strobe's inactive level so reset never fakes a release.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         chain <= '1;
         prev  <= 1'b1;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pin};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;

endmodule

// File: rtl/pic_bus_control_seq.sv
// Bus interface and ICW/OCW sequencer for an 8259A-style PIC.
// Optional sticky dropped-write flag built when PIC_BUS_WRITE_ERROR_EN is defined.
module pic_bus_control_seq
   import pic_bus_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cs_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic                  address,
   input  logic [DATA_WIDTH-1:0] data_bus_in,
   output logic [DATA_WIDTH-1:0] internal_data_bus,
   output logic                  write_icw1,
   output logic                  write_icw2,
   output logic                  write_icw3,
   output logic                  write_icw4,
   output logic                  write_ocw1,
   output logic                  write_ocw2,
   output logic                  write_ocw3,
   output logic                  read,
   output logic                  read_isr,
   output logic                  poll_cmd,
   output logic                  init_done,
   output logic                  single_mode,
   output logic                  write_error
);

   logic                   wr_sync, wr_rise;
   logic                   rd_sync, rd_rise_unused;
   logic [SYNC_STAGES-1:0] cs_chain;
   logic                   cs_sync;

   pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .pin     (wr_n),
      .level   (wr_sync),
      .rise    (wr_rise)
   );

   pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .pin     (rd_n),
      .level   (rd_sync),
      .rise    (rd_rise_unused)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) cs_chain <= '1;
      else          cs_chain <= {cs_chain[SYNC_STAGES-2:0], cs_n};
   end
   assign cs_sync = cs_chain[SYNC_STAGES-1];

   pic_state_t            state;
   logic                  wr_armed;
   logic                  latched_a0;
   logic                  ic4;
   logic [DATA_WIDTH-1:0] latched_data;
   logic                  commit;
   logic                  is_icw1;

   // A write is decoded on WR release, so CS may already be gone by then.
   assign commit  = wr_rise & wr_armed;
   assign is_icw1 = ~latched_a0 & latched_data[ICW1_SEL];
   assign internal_data_bus = latched_data;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= IDLE;
         wr_armed     <= 1'b0;
         latched_a0   <= 1'b0;
         latched_data <= '0;
         ic4          <= 1'b0;
         write_icw1   <= 1'b0;
         write_icw2   <= 1'b0;
         write_icw3   <= 1'b0;
         write_icw4   <= 1'b0;
         write_ocw1   <= 1'b0;
         write_ocw2   <= 1'b0;
         write_ocw3   <= 1'b0;
         poll_cmd     <= 1'b0;
         read         <= 1'b0;
         read_isr     <= 1'b0;
         init_done    <= 1'b0;
         single_mode  <= 1'b0;
      end else begin
         write_icw1 <= 1'b0;
         write_icw2 <= 1'b0;
         write_icw3 <= 1'b0;
         write_icw4 <= 1'b0;
         write_ocw1 <= 1'b0;
         write_ocw2 <= 1'b0;
         write_ocw3 <= 1'b0;
         poll_cmd   <= 1'b0;
         read       <= ~rd_sync & ~cs_sync;

         if (!wr_sync && !cs_sync) begin
            wr_armed     <= 1'b1;
            latched_a0   <= address;
            latched_data <= data_bus_in;
         end else if (commit) begin
            wr_armed <= 1'b0;
            if (is_icw1) begin
               write_icw1  <= 1'b1;
               init_done   <= 1'b0;
               single_mode <= latched_data[SNGL];
               ic4         <= latched_data[IC4];
               read_isr    <= 1'b0;
               state       <= WAIT_ICW2;
            end else begin
               // Writes that fit no slot of the current state fall through untouched.
               case (state)
                  WAIT_ICW2: if (latched_a0) begin
                     write_icw2 <= 1'b1;
                     if (!single_mode) state <= WAIT_ICW3;
                     else if (ic4)     state <= WAIT_ICW4;
                     else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  WAIT_ICW3: if (latched_a0) begin
                     write_icw3 <= 1'b1;
                     if (ic4) state <= WAIT_ICW4;
                     else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  WAIT_ICW4: if (latched_a0) begin
                     write_icw4 <= 1'b1;
                     state      <= READY;
                     init_done  <= 1'b1;
                  end
                  READY: begin
                     if (latched_a0) write_ocw1 <= 1'b1;
                     else if (latched_data[OCW3_SEL]) begin
                        write_ocw3 <= 1'b1;
                        poll_cmd   <= latched_data[OCW3_P];
                        if (latched_data[OCW3_RR]) read_isr <= latched_data[OCW3_RIS];
                     end else write_ocw2 <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef PIC_BUS_WRITE_ERROR_EN
   logic drop;
   logic error_flag;

   always_comb begin
      drop = 1'b0;
      if (commit && !is_icw1) begin
         case (state)
            IDLE:                            drop = 1'b1;
            WAIT_ICW2, WAIT_ICW3, WAIT_ICW4: drop = ~latched_a0;
            default:                         drop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)                error_flag <= 1'b0;
      else if (commit && is_icw1)  error_flag <= 1'b0;
      else if (drop)               error_flag <= 1'b1;
   end

   assign write_error = error_flag;
`else
   assign write_error = 1'b0;
`endif

endmodule

// File: tb/tb_pic_bus_control_seq.sv
// Directed self-checking bench for pic_bus_control_seq (SYNC_STAGES=3); honours PIC_BUS_WRITE_ERROR_EN.
module tb_pic_bus_control_seq;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       cs_n, rd_n, wr_n, address;
   logic [7:0] data_bus_in;
   logic [7:0] internal_data_bus;
   logic       write_icw1, write_icw2, write_icw3, write_icw4;
   logic       write_ocw1, write_ocw2, write_ocw3;
   logic       read, read_isr, poll_cmd, init_done, single_mode, write_error;

`ifdef PIC_BUS_WRITE_ERROR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   pic_bus_control_seq #(.DATA_WIDTH(8), .SYNC_STAGES(3)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .cs_n              (cs_n),
      .rd_n              (rd_n),
      .wr_n              (wr_n),
      .address           (address),
      .data_bus_in       (data_bus_in),
      .internal_data_bus (internal_data_bus),
      .write_icw1        (write_icw1),
      .write_icw2        (write_icw2),
      .write_icw3        (write_icw3),
      .write_icw4        (write_icw4),
      .write_ocw1        (write_ocw1),
      .write_ocw2        (write_ocw2),
      .write_ocw3        (write_ocw3),
      .read              (read),
      .read_isr          (read_isr),
      .poll_cmd          (poll_cmd),
      .init_done         (init_done),
      .single_mode       (single_mode),
      .write_error       (write_error)
   );

   always #5 clock = ~clock;

   logic [6:0]  strobes;
   logic [20:0] all_outputs;
   assign strobes = {write_icw1, write_icw2, write_icw3, write_icw4, write_ocw1, write_ocw2, write_ocw3};
   assign all_outputs = {strobes, read, read_isr, poll_cmd, init_done, single_mode, write_error, internal_data_bus};

   int         tests = 0;
   int         fails = 0;
   int         multi_total = 0;
   logic [6:0] seen_vec;
   int         seen_cycle, pulse_cycles, poll_cycles;
   logic [7:0] seen_bus;
   logic       seen_init, seen_poll;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One host write; WR is released in loop cycle 0 and the strobes are watched for ten cycles.
   task automatic applyStimulus(input logic a0, input logic [7:0] d, input logic cs_early);
      @(posedge clock); #1;
      cs_n = 1'b0; address = a0; data_bus_in = d; wr_n = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      if (cs_early) begin
         cs_n = 1'b1;
         @(posedge clock); #1;
      end
      wr_n = 1'b1;
      seen_vec = '0; seen_cycle = 0; pulse_cycles = 0; poll_cycles = 0;
      seen_bus = '0; seen_init = 1'b0; seen_poll = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clock); #1;
         if (i == 1) cs_n = 1'b1;
         if (strobes != '0) begin
            pulse_cycles++;
            if (!$onehot(strobes)) multi_total++;
            if (seen_cycle == 0) begin
               seen_cycle = i; seen_vec = strobes; seen_bus = internal_data_bus;
               seen_init = init_done; seen_poll = poll_cmd;
            end
         end
         if (poll_cmd) poll_cycles++;
      end
   endtask

   initial begin
      reset_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; address = 1'b0; data_bus_in = '0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_outputs", 32'(all_outputs), 32'h0);
      reset_n = 1'b1;

      applyStimulus(1'b0, 8'h20, 1'b0);
      checkOutput("idle_drop_strobe", 32'(seen_vec), 32'h00);
      checkOutput("idle_drop_error", 32'(write_error), 32'(ERR_ON));

      applyStimulus(1'b0, 8'h13, 1'b0);
      checkOutput("icw1_strobe", 32'(seen_vec), 32'h40);
      checkOutput("icw1_latency", 32'(seen_cycle), 32'd4);
      checkOutput("icw1_width", 32'(pulse_cycles), 32'd1);
      checkOutput("icw1_clears_error", 32'(write_error), 32'h0);
      checkOutput("single_mode_set", 32'(single_mode), 32'h1);
      applyStimulus(1'b1, 8'h20, 1'b0);
      checkOutput("sngl_icw2_strobe", 32'(seen_vec), 32'h20);
      checkOutput("sngl_icw2_init", 32'(seen_init), 32'h0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      checkOutput("sngl_icw4_strobe", 32'(seen_vec), 32'h08);
      checkOutput("sngl_icw4_init", 32'(seen_init), 32'h1);

      applyStimulus(1'b0, 8'h11, 1'b0);
      checkOutput("casc_icw1_strobe", 32'(seen_vec), 32'h40);
      checkOutput("casc_init_cleared", 32'(init_done), 32'h0);
      checkOutput("casc_single_mode", 32'(single_mode), 32'h0);
      applyStimulus(1'b0, 8'h05, 1'b0);
      checkOutput("wait_drop_strobe", 32'(seen_vec), 32'h00);
      checkOutput("wait_drop_error", 32'(write_error), 32'(ERR_ON));
      applyStimulus(1'b1, 8'h08, 1'b0);
      checkOutput("casc_icw2_strobe", 32'(seen_vec), 32'h20);
      applyStimulus(1'b1, 8'h04, 1'b0);
      checkOutput("casc_icw3_strobe", 32'(seen_vec), 32'h10);
      checkOutput("casc_icw3_init", 32'(seen_init), 32'h0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      checkOutput("casc_icw4_strobe", 32'(seen_vec), 32'h08);
      checkOutput("casc_icw4_init", 32'(seen_init), 32'h1);

      applyStimulus(1'b1, 8'hFB, 1'b0);
      checkOutput("ocw1_strobe", 32'(seen_vec), 32'h04);
      checkOutput("ocw1_bus", 32'(seen_bus), 32'hFB);
      applyStimulus(1'b0, 8'h20, 1'b0);
      checkOutput("ocw2_strobe", 32'(seen_vec), 32'h02);
      checkOutput("ocw2_bus", 32'(seen_bus), 32'h20);
      applyStimulus(1'b0, 8'h0B, 1'b0);
      checkOutput("ocw3_rr_strobe", 32'(seen_vec), 32'h01);
      checkOutput("ocw3_rr_bus", 32'(seen_bus), 32'h0B);
      checkOutput("ocw3_read_isr", 32'(read_isr), 32'h1);
      checkOutput("ocw3_no_poll", 32'(poll_cycles), 32'd0);
      applyStimulus(1'b0, 8'h0C, 1'b0);
      checkOutput("ocw3_poll_strobe", 32'(seen_vec), 32'h01);
      checkOutput("ocw3_poll_with_strobe", 32'(seen_poll), 32'h1);
      checkOutput("ocw3_poll_width", 32'(poll_cycles), 32'd1);
      checkOutput("ocw3_read_isr_kept", 32'(read_isr), 32'h1);

      applyStimulus(1'b1, 8'hA5, 1'b1);
      checkOutput("cs_early_strobe", 32'(seen_vec), 32'h04);
      checkOutput("cs_early_latency", 32'(seen_cycle), 32'd4);
      checkOutput("cs_early_bus", 32'(seen_bus), 32'hA5);

      @(posedge clock); #1;
      cs_n = 1'b0; rd_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("read_not_yet", 32'(read), 32'h0);
      @(posedge clock); #1;
      checkOutput("read_asserted", 32'(read), 32'h1);
      cs_n = 1'b1; rd_n = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("read_released", 32'(read), 32'h0);

      applyStimulus(1'b0, 8'h11, 1'b0);
      checkOutput("reicw1_read_isr", 32'(read_isr), 32'h0);
      applyStimulus(1'b1, 8'h08, 1'b0);
      checkOutput("reicw2_strobe", 32'(seen_vec), 32'h20);
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      checkOutput("midreset_outputs", 32'(all_outputs), 32'h0);
      reset_n = 1'b1;
      applyStimulus(1'b1, 8'h04, 1'b0);
      checkOutput("postreset_icw3_drop", 32'(seen_vec), 32'h00);
      checkOutput("postreset_init", 32'(init_done), 32'h0);
      checkOutput("postreset_error", 32'(write_error), 32'(ERR_ON));

      checkOutput("strobes_onehot", 32'(multi_total), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pic_bus_control_seq.md
Name: pic_bus_control_seq

Overview:
- Clocked, parametrised bus interface and initialisation sequencer for the 8259A-style PIC.
- Synchronises the host strobes (cs_n/rd_n/wr_n) into the core clock and latches the written data.
- Tracks the ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence with a state machine, then decodes OCW1–3.
- Drives one-cycle write strobes, read-register select and poll request to the IRR/ISR/IMR and priority logic.

Parameters:
- DATA_WIDTH, 8, width of host/internal data bus; must be ≥8. Bits [DATA_WIDTH-1:8] pass through and are ignored by decode.
- SYNC_STAGES, 2, flip-flop stages in each strobe synchroniser; must be ≥2.

Ports:
- clock  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- cs_n  in  1  chip select, active low, asynchronous to clock
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- address  in  1  A0
- data_bus_in  in  DATA_WIDTH  host write data
- internal_data_bus  out  DATA_WIDTH  latched write data, valid while any write strobe is high
- write_icw1, write_icw2, write_icw3, write_icw4  out  1 each  one-cycle ICW strobes
- write_ocw1, write_ocw2, write_ocw3  out  1 each  one-cycle OCW strobes
- read  out  1  synchronised level: cs_n=0 and rd_n=0
- read_isr  out  1  0 selects IRR, 1 selects ISR for status reads
- poll_cmd  out  1  one-cycle pulse on OCW3 with P=1
- init_done  out  1  high once the init sequence completes
- single_mode  out  1  latched SNGL (ICW1 D1)
- write_error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, every output 0, synchroniser chains forced to the inactive level (1).
- Synchronisers: wr_n, rd_n and cs_n each pass through SYNC_STAGES flops.
- Write capture: in every cycle where synced wr_n=0 and synced cs_n=0, latch address and data_bus_in and set wr_armed.
- Write commit: on a synced wr_n 0→1 transition with wr_armed=1, decode the latched word. The strobe goes high the next cycle for exactly one cycle, then wr_armed clears.
- Latency: pin WR rising edge → strobe = SYNC_STAGES+1 clocks.
- If CS deasserts before WR rises but after capture, the write still commits.
- Decode (A0 / D4 / D3): A0=0,D4=1 is ICW1 in any state. In READY: A0=1 → OCW1; A0=0,D4=0,D3=0 → OCW2; A0=0,D4=0,D3=1 → OCW3.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - ICW1 from any state: init_done←0, single_mode←D1, ic4←D0, read_isr←0, → WAIT_ICW2.
  - WAIT_ICW2, A0=1: write_icw2; → WAIT_ICW3 if !single_mode, else WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW3, A0=1: write_icw3; → WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW4, A0=1: write_icw4; → READY.
  - Entering READY sets init_done=1 in the same cycle as the final ICW strobe.
  - IDLE: all non-ICW1 writes are dropped, no strobe.
  - WAIT_* states: an A0=0 non-ICW1 write is dropped, no strobe, no state change.
- OCW3 side effects (in the strobe cycle):
  - RR=D1=1 → read_isr←RIS=D0; RR=0 leaves read_isr unchanged.
  - P=D2=1 → poll_cmd pulses with write_ocw3.
- read: registered (synced rd_n=0 and synced cs_n=0). Independent of the FSM and valid in every state.
- At most one write strobe is high in any cycle.
- A reset asserted mid-sequence returns to IDLE and drops a pending write.

Optional Feature:
- Macro: PIC_BUS_WRITE_ERROR_EN.
- Defined: write_error is set (sticky) by any dropped write, i.e. a non-ICW1 write in IDLE or an A0=0 non-ICW1 write in a WAIT_* state. Cleared by ICW1 or reset.
- Undefined: write_error is tied to 0 and no error logic is built.

Decomposition:
- Package pic_bus_pkg:
  - state enum for the FSM states.
  - bit-position constants ICW1_SEL=4, OCW3_SEL=3, SNGL=1, IC4=0, OCW3_RR=1, OCW3_RIS=0, OCW3_P=2.
- Sub-module pic_strobe_sync: SYNC_STAGES synchroniser plus rise detector. Instanced for wr_n and rd_n; cs_n uses a plain synchroniser.

Test Plan:
- ICW1=0x13 (A0=0), then ICW2=0x20 (A0=1), then ICW4=0x01 (A0=1) → write_icw1, write_icw2, write_icw4 pulses; no write_icw3; single_mode=1; init_done=1 in the ICW4 strobe cycle.
- ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x01 → all four ICW strobes in order; single_mode=0; init_done=1.
- After init: OCW1 0xFB (A0=1), OCW2 0x20, OCW3 0x0B → write_ocw1, write_ocw2, write_ocw3 pulses with internal_data_bus matching; read_isr=1 after OCW3. Then OCW3 0x0C → poll_cmd=1 for one cycle and read_isr stays 1.
- Pin WR rising edge at cycle t with SYNC_STAGES=3 → strobe high only in cycle t+4.
- Write 0x20 (A0=0) before any ICW1 → no strobe. With PIC_BUS_WRITE_ERROR_EN, write_error=1; a following ICW1 clears it.
- reset_n=0 for one cycle between ICW2 and ICW3 → state IDLE, init_done=0; the later ICW3 write is dropped.
